// File: rtl/quantize_stream.sv
`default_nettype none
// ============================================================================
// quantize_stream: scales signed activations by a latched Q8.24 reciprocal,
// rounds half away from zero and saturates to symmetric int8. Rev 1.0
// ============================================================================
module quantize_stream #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 24,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      scale_in,
    input  logic             scale_valid,
    output logic             scale_loaded,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int                PROD_W  = IN_W + 33;
    localparam logic [PROD_W-1:0] C_HALF  = PROD_W'(1) << (FRAC_BITS - 1);
    localparam logic [PROD_W-1:0] C_QMAX  = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [LEN_W-1:0]  C_LEN1  = LEN_W'(1);
    localparam logic [OUT_W-1:0]  C_OUT1  = OUT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        scale_q, scale_d;
    logic               scale_loaded_q, scale_loaded_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   in_count_q, in_count_d;
    logic [LEN_W-1:0]   out_count_q, out_count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic               w_en;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_out_hs;
    logic [PROD_W-1:0]  w_a_ext;
    logic [PROD_W-1:0]  w_b_ext;
    logic               w_neg;
    logic [PROD_W-1:0]  w_mag;
    logic [PROD_W-1:0]  w_q_full;
    logic [OUT_W-1:0]   w_q_sat;
    logic [OUT_W-1:0]   w_quant;

    assign w_en       = !out_valid_q || out_ready;
    assign w_in_ready = (state_q == ST_RUN) && (in_count_q < len_q) && w_en;
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = out_valid_q && out_ready;

    // Operands are widened to the full product width so the multiply is exact.
    assign w_a_ext = PROD_W'($signed(in_data));
    assign w_b_ext = PROD_W'($signed({1'b0, scale_q}));

    // Quantizer works on the magnitude so rounding is symmetric about zero.
    assign w_neg    = s1_prod_q[PROD_W-1];
    assign w_mag    = w_neg ? (~s1_prod_q + PROD_W'(1)) : s1_prod_q;
    assign w_q_full = (w_mag + C_HALF) >> FRAC_BITS;
    assign w_q_sat  = (w_q_full > C_QMAX) ? C_QMAX[OUT_W-1:0] : w_q_full[OUT_W-1:0];
    assign w_quant  = w_neg ? (~w_q_sat + C_OUT1) : w_q_sat;

    always_comb begin
        state_d        = state_q;
        scale_d        = scale_q;
        scale_loaded_d = scale_loaded_q;
        len_d          = len_q;
        in_count_d     = in_count_q;
        out_count_d    = out_count_q;
        done_d         = 1'b0;
        s1_valid_d     = s1_valid_q;
        s1_prod_d      = s1_prod_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (scale_valid) begin
                    scale_d        = scale_in;
                    scale_loaded_d = 1'b1;
                end
                if (start && scale_loaded_q && (vec_len != '0)) begin
                    state_d     = ST_RUN;
                    len_d       = vec_len;
                    in_count_d  = '0;
                    out_count_d = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    in_count_d = in_count_q + C_LEN1;
                    if (in_count_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_out_hs) begin
            out_count_d = out_count_q + C_LEN1;
        end

        // The final handshake ends the vector regardless of which busy state we are in.
        if ((state_q != ST_IDLE) && w_out_hs && out_last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end

        if (w_en) begin
            s1_valid_d  = w_accept;
            s1_prod_d   = w_a_ext * w_b_ext;
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? w_quant : '0;
            out_last_d  = s1_valid_q && (out_count_d == (len_q - C_LEN1));
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            scale_q        <= '0;
            scale_loaded_q <= 1'b0;
            len_q          <= '0;
            in_count_q     <= '0;
            out_count_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_prod_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            scale_q        <= scale_d;
            scale_loaded_q <= scale_loaded_d;
            len_q          <= len_d;
            in_count_q     <= in_count_d;
            out_count_q    <= out_count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            s1_valid_q     <= s1_valid_d;
            s1_prod_q      <= s1_prod_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
        end
    end

    assign scale_loaded = scale_loaded_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign in_ready     = w_in_ready;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;

endmodule
`default_nettype wire
